// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults, derived totals and display_addr field split for the
// 800x600@72 Hz raster generator.
package vga_timing_gen_pkg;

    // Counter width; every window compare is unsigned at this width.
    localparam int CW = 11;

    // Default 800x600@72 Hz timing (50 MHz pixel clock).
    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 56;
    localparam int DEF_H_SYNC    = 120;
    localparam int DEF_H_BACK    = 64;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 37;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BACK    = 23;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // display_addr = {x, y}
    localparam int X_MSB = 21;
    localparam int X_LSB = 11;
    localparam int Y_MSB = 10;

    // Registered pin bundle.
    typedef struct packed {
        logic [2:0] rgb;
        logic       hsync;
        logic       vsync;
        logic       active;
        logic       frame_start;
    } vga_out_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus visible and sync window decodes.
// Used once for the horizontal axis and once for the vertical axis.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
(
    input  logic          sysclk,
    input  logic          reset,
    input  logic          en,
    input  logic [CW-1:0] total,
    input  logic [CW-1:0] vis_len,
    input  logic [CW-1:0] sync_start,
    input  logic [CW-1:0] sync_end,     // exclusive
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          visible,
    output logic          in_sync
);

    assign wrap    = en && (cnt == total - CW'(1));
    assign visible = cnt < vis_len;
    assign in_sync = (cnt >= sync_start) && (cnt < sync_end);

    // Advance when enabled, wrap to 0 at the end of the axis.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing stage: scans the frame, presents {x, y} to the GPU and
// registers the returned colour into blanked RGB aligned with HSYNC/VSYNC.
// Build option VGA_DATA_REG_EN: adds a capture register on display_data so the
// GPU gets a full cycle; all outputs then trail display_addr by 2 clocks.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [2:0]  display_data,
    output logic [21:0] display_addr,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        active,
    output logic        frame_start
);

    localparam int H_TOT_I = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT_I = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOT_I > 2048 || V_TOT_I > 2048) begin : g_bad_timing
        $error("vga_timing_gen: totals must fit 11-bit counters");
    end

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, v_wrap_unused;
    logic          h_vis, v_vis, h_in_sync, v_in_sync;

    vga_axis_counter u_h (
        .sysclk     (sysclk),
        .reset      (reset),
        .en         (1'b1),
        .total      (CW'(H_TOT_I)),
        .vis_len    (CW'(H_VISIBLE)),
        .sync_start (CW'(H_VISIBLE + H_FRONT)),
        .sync_end   (CW'(H_VISIBLE + H_FRONT + H_SYNC)),
        .cnt        (h_cnt),
        .wrap       (h_wrap),
        .visible    (h_vis),
        .in_sync    (h_in_sync)
    );

    vga_axis_counter u_v (
        .sysclk     (sysclk),
        .reset      (reset),
        .en         (h_wrap),
        .total      (CW'(V_TOT_I)),
        .vis_len    (CW'(V_VISIBLE)),
        .sync_start (CW'(V_VISIBLE + V_FRONT)),
        .sync_end   (CW'(V_VISIBLE + V_FRONT + V_SYNC)),
        .cnt        (v_cnt),
        .wrap       (v_wrap_unused),
        .visible    (v_vis),
        .in_sync    (v_in_sync)
    );

    assign display_addr = {h_cnt, v_cnt};

    logic       vis_now, fs_now;
    logic [2:0] data_s;
    logic       vis_s, hs_s, vs_s, fs_s;

    assign vis_now = h_vis && v_vis;
    assign fs_now  = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_DATA_REG_EN
    logic [2:0] data_q;
    logic       vis_q, hs_q, vs_q, fs_q;

    // Capture GPU data with the decodes of the address that produced it.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            {data_q, vis_q, hs_q, vs_q, fs_q} <= '0;
        else
            {data_q, vis_q, hs_q, vs_q, fs_q} <=
                {display_data, vis_now, h_in_sync, v_in_sync, fs_now};
    end

    assign {data_s, vis_s, hs_s, vs_s, fs_s} = {data_q, vis_q, hs_q, vs_q, fs_q};
`else
    assign {data_s, vis_s, hs_s, vs_s, fs_s} =
        {display_data, vis_now, h_in_sync, v_in_sync, fs_now};
`endif

    vga_out_t out_q;

    // Pin register: blank RGB outside the visible area, apply sync polarity.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            out_q <= '{rgb: 3'b000, hsync: ~SYNC_POL, vsync: ~SYNC_POL,
                       active: 1'b0, frame_start: 1'b0};
        end else begin
            out_q.rgb         <= vis_s ? data_s : 3'b000;
            out_q.hsync       <= hs_s ? SYNC_POL : ~SYNC_POL;
            out_q.vsync       <= vs_s ? SYNC_POL : ~SYNC_POL;
            out_q.active      <= vis_s;
            out_q.frame_start <= fs_s;
        end
    end

    assign {vga_r, vga_g, vga_b} = out_q.rgb;
    assign vga_hsync             = out_q.hsync;
    assign vga_vsync             = out_q.vsync;
    assign active                = out_q.active;
    assign frame_start           = out_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a shrunken-timing
// instance (inverted sync polarity) share clock, reset and random colour data.
// A raster-position model derived from the clock count predicts every output.
module tb_vga_timing_gen;

`ifdef VGA_DATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // Shrunken timing: 64 x 30 total, 1920 clocks per frame.
    localparam int SHV = 40, SHF = 6, SHS = 8, SHB = 10;
    localparam int SVV = 20, SVF = 3, SVS = 2, SVB = 5;
    localparam int S_FRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [2:0]  display_data = 3'b000;
    logic [21:0] addr_s, addr_d;
    logic        r_s, g_s, b_s, hs_s, vs_s, act_s, fs_s;
    logic        r_d, g_d, b_d, hs_d, vs_d, act_d, fs_d;

    always #10 sysclk = ~sysclk;

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_POL(1'b0)
    ) dut (
        .sysclk(sysclk), .reset(reset), .display_data(display_data),
        .display_addr(addr_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
        .vga_hsync(hs_s), .vga_vsync(vs_s), .active(act_s), .frame_start(fs_s)
    );

    vga_timing_gen dut_def (
        .sysclk(sysclk), .reset(reset), .display_data(display_data),
        .display_addr(addr_d), .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
        .vga_hsync(hs_d), .vga_vsync(vs_d), .active(act_d), .frame_start(fs_d)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [21:0] addr;
        logic [2:0]  rgb;
        logic        hs, vs, act, fs;
    } obs_t;

    // Expected outputs k clock edges after reset release, from raster position.
    function automatic obs_t ref_out(input int k, input int hv, input int hf, input int hsw,
                                     input int hb, input int vv, input int vf, input int vsw,
                                     input int vb, input logic pol, input logic [2:0] d);
        obs_t o;
        int ht, vt, t, x, y;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        t  = k % (ht * vt);
        o.addr = {11'(t % ht), 11'(t / ht)};
        if (k < LAT) begin
            o.rgb = 3'b000; o.hs = !pol; o.vs = !pol; o.act = 1'b0; o.fs = 1'b0;
        end else begin
            t = (k - LAT) % (ht * vt);
            x = t % ht;
            y = t / ht;
            o.act = (x < hv) && (y < vv);
            o.rgb = o.act ? d : 3'b000;
            o.hs  = (x >= hv + hf && x < hv + hf + hsw) ? pol : !pol;
            o.vs  = (y >= vv + vf && y < vv + vf + vsw) ? pol : !pol;
            o.fs  = (t == 0);
        end
        return o;
    endfunction

    // Clock edges since reset release.
    int ek = 0;
    always @(posedge sysclk or posedge reset) begin
        if (reset) ek <= 0;
        else       ek <= ek + 1;
    end

    // Data present before edge j is stored at hist[j].
    logic [2:0] hist [0:65535];
    bit         mode = 1'b0;   // 0: random colour, 1: colour = x mod 8 of small dut

    // Every falling edge: compare both instances, then present next data.
    always @(negedge sysclk) begin
        obs_t       e;
        logic [2:0] d, nd;
        int         idx;
        idx = ek - LAT + 1;
        d   = (idx >= 0) ? hist[idx] : 3'b000;
        e   = ref_out(ek, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0, d);
        check("small_cyc", 32'({addr_s, r_s, g_s, b_s, hs_s, vs_s, act_s, fs_s}), 32'(e));
        e   = ref_out(ek, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, d);
        check("dflt_cyc", 32'({addr_d, r_d, g_d, b_d, hs_d, vs_d, act_d, fs_d}), 32'(e));
        nd = mode ? addr_s[13:11] : 3'($urandom);
        hist[ek + 1] = nd;
        display_data = nd;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"}, 32'({addr_s, addr_d}), 32'(0));
        check({tag, "_rgb"},  32'({r_s, g_s, b_s, r_d, g_d, b_d}), 32'(0));
        check({tag, "_sync"}, 32'({hs_s, vs_s, hs_d, vs_d}), 32'(4'b1100));
        check({tag, "_flags"}, 32'({act_s, fs_s, act_d, fs_d}), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge sysclk);
        check_reset_vals("rst_init");
        reset = 1'b0;
        @(posedge sysclk); #1;
        check("addr_x1_s", 32'(addr_s), 32'(22'h000800));
        check("addr_x1_d", 32'(addr_d), 32'(22'h000800));

        // Mid-line reset held for 5 clocks; outputs must drop without an edge.
        repeat (300) @(posedge sysclk);
        #5 reset = 1'b1;
        #1 check_reset_vals("rst_async");
        repeat (5) @(posedge sysclk);
        #1 check_reset_vals("rst_hold");
        @(negedge sysclk) reset = 1'b0;

        // Several full small frames of random colour.
        repeat (3 * S_FRAME) @(posedge sysclk);

        // Colour tied to x to show RGB alignment with the address.
        mode = 1'b1;
        repeat (S_FRAME + 50) @(posedge sysclk);
        mode = 1'b0;

        // Reset mid-frame at (20, 10) of the small raster.
        @(negedge sysclk) reset = 1'b1;
        @(negedge sysclk) reset = 1'b0;
        repeat (10 * (SHV + SHF + SHS + SHB) + 20) @(posedge sysclk);
        #1 check("mid_pos", 32'(addr_s), 32'({11'd20, 11'd10}));
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_mid");
        @(negedge sysclk) reset = 1'b0;
        repeat (2 * S_FRAME) @(posedge sysclk);
        @(negedge sysclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
